fpnew_classifier_pipe: RTL and testbench
========================================

# fpnew_classifier_pipe

Pipelined, multi-format floating-point classifier with valid/ready handshake. It classifies up to `NumOperands` operands held in a `Width`-bit register. The source format is selected per transaction, and NaN-boxing is checked internally. Each transaction returns the per-operand `fpnew_pkg::fp_info_t` and a RISC-V `fclass` 10-bit mask. It sits beside the FPU operation groups as a standalone classify path and as a reusable pre-stage for units that need registered operand info.

## Interface
- `Width`, default 64: operand register width (FLEN); must be at least the widest format used.
- `NumOperands`, default 3: operands classified per transaction.
- `NumPipeRegs`, default 1: number of register stages. 0 gives a purely combinational path.
- `EnableNanBox`, default 1: 1 applies the NaN-boxing check; 0 treats every operand as boxed.
- `TagWidth`, default 1: width of the opaque tag carried alongside the data.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `in_valid_i`, in, 1: input transaction valid.
- `in_ready_o`, out, 1: input accepted when high.
- `operands_i`, in, `NumOperands*Width`: raw operands.
- `src_fmt_i`, in, `fpnew_pkg::fp_format_e`: format of all operands in this transaction.
- `tag_i`, in, `TagWidth`: tag, passed through unchanged.
- `flush_i`, in, 1: kill all in-flight transactions.
- `out_valid_o`, out, 1: result valid.
- `out_ready_i`, in, 1: downstream accepts the result.
- `info_o`, out, `NumOperands` x `fp_info_t`: per-operand classification.
- `class_mask_o`, out, `NumOperands*10`: one-hot `fclass` mask per operand.
- `fmt_err_o`, out, 1: `src_fmt_i` is wider than `Width`.
- `tag_o`, out, `TagWidth`: tag of the current output.
- `busy_o`, out, 1: any stage holds a valid transaction.

## Operation
- **Extraction.** Format width w, exponent bits and mantissa bits come from the `fpnew_pkg` functions. The value is `operands_i[op][w-1:0]`.
- **Boxing.** An operand is boxed iff `EnableNanBox==0`, or w==`Width`, or `operands_i[op][Width-1:w]` is all ones.
- **Classification.** Same rules for every format:
  - normal: exponent is neither 0 nor all-ones.
  - zero: exponent 0 and mantissa 0.
  - subnormal: exponent 0 and mantissa nonzero.
  - inf: exponent all-ones and mantissa 0.
  - NaN: exponent all-ones and mantissa nonzero, or the operand is unboxed.
  - signalling: boxed NaN with mantissa MSB = 0.
  - quiet: NaN and not signalling.
  - All categories except NaN and quiet are gated by boxed.
- **Class mask.** Exactly one bit is set per operand:
  - bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0.
  - bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf.
  - bit8 sNaN, bit9 qNaN.
  - Unboxed operands give bit9 only. Sign is ignored for NaN.
- **Illegal format.** If the format width exceeds `Width`, `fmt_err_o`=1, `info_o` is all zero and `class_mask_o` is all zero. The transaction still flows through the pipeline normally.
- **Pipeline.** Elastic pipeline with per-stage valid. Stage k is ready iff `!valid_q[k]` or stage k+1 is ready. The last stage's ready is `out_ready_i`. `in_ready_o` is stage 0's ready. A stage loads data only on its input handshake; otherwise it holds.
- **Flush.** `flush_i` clears every `valid_q` on the next edge. Data registers are unchanged. Input presented in the same cycle as a flush is accepted (handshake completes) but discarded.

## Timing
- **Latency.** `NumPipeRegs` cycles from input handshake to `out_valid_o`. With 0 stages, outputs are combinational from the inputs and `in_ready_o` = `out_ready_i`.
- **Throughput.** 1 transaction/cycle while `out_ready_i`=1.
- **Backpressure.** Full throughput is sustained with no bubbles. A stalled output holds `info_o`, `class_mask_o`, `tag_o` and `fmt_err_o` stable until the handshake completes.
- **Reset.** While `rst_i` is high, all valids clear and all data registers clear, so:
  - `out_valid_o`=0, `busy_o`=0.
  - `info_o`, `class_mask_o`, `tag_o`, `fmt_err_o` are all 0.
  - `in_ready_o`=1 from the first cycle after reset.
  - Reset mid-stream drops all transactions with no partial outputs.
- **Flush/reset priority.** Reset beats flush; flush beats load.
- **`busy_o`.** OR of all `valid_q`; combinational; 0 when `NumPipeRegs`=0.

## Structure
- **Package additions to `fpnew_pkg`:**
  - `classmask_e` with the 10 bit positions above.
  - A `CLASS_BITS`=10 constant.
- **Sub-module `fpnew_classify_fmt`.** Combinational: one operand plus format in, `fp_info_t`, mask and format-error out. It is instantiated `NumOperands` times ahead of the pipeline.
- **Top level.** Pipeline registers live in the top via a generate loop over stages.

## Test plan
- **FP32, Width=64, NumPipeRegs=1, NanBox on.** Operand `0xFFFFFFFF_3F800000` → mask 0x040 (+normal) one cycle later. Same value with upper half `0x00000000` → mask 0x200, `is_boxed`=0.
- **FP64 values.** `0x7FF0000000000000` → 0x080; `0x7FF4000000000000` → 0x100 (sNaN); `0xFFF8000000000000` → 0x200; `0x8000000000000000` → 0x008; `0x0000000000000001` → 0x020.
- **FP16 boxed sweep.** Values `0xFC00`, `0x8001`, `0x7E00` → 0x001, 0x004, 0x200.
- **Backpressure.** `NumPipeRegs`=3, continuous input, `out_ready_i` toggled randomly. Required: every tag in order, none lost or duplicated, outputs stable while stalled, full throughput once ready is held high.
- **Flush and reset mid-stream.** `flush_i` with 3 transactions in flight → `out_valid_o`=0 and `busy_o`=0 next cycle, and the next input emerges after 3 cycles. `rst_i` mid-stream → all outputs 0 the following cycle.
- **Illegal format.** `Width`=32 with `src_fmt`=FP64 → `fmt_err_o`=1, mask 0, tag preserved.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Floating-point format definitions and classification types shared by the classifier pipeline.
package fpnew_pkg;

   localparam int unsigned FP_FORMAT_BITS = 3;
   localparam int unsigned CLASS_BITS     = 10;

   typedef enum logic [FP_FORMAT_BITS-1:0] {
      FP32    = 3'd0,
      FP64    = 3'd1,
      FP16    = 3'd2,
      FP8     = 3'd3,
      FP16ALT = 3'd4
   } fp_format_e;

   typedef struct packed {
      logic is_normal;
      logic is_subnormal;
      logic is_zero;
      logic is_inf;
      logic is_nan;
      logic is_signalling;
      logic is_quiet;
      logic is_boxed;
   } fp_info_t;

   // Bit positions of the RISC-V fclass result
   typedef enum logic [3:0] {
      CLASS_NEG_INF     = 4'd0,
      CLASS_NEG_NORM    = 4'd1,
      CLASS_NEG_SUBNORM = 4'd2,
      CLASS_NEG_ZERO    = 4'd3,
      CLASS_POS_ZERO    = 4'd4,
      CLASS_POS_SUBNORM = 4'd5,
      CLASS_POS_NORM    = 4'd6,
      CLASS_POS_INF     = 4'd7,
      CLASS_SNAN        = 4'd8,
      CLASS_QNAN        = 4'd9
   } classmask_e;

   function automatic int unsigned exp_bits(input fp_format_e fmt);
      case (fmt)
         FP64:    return 11;
         FP16:    return 5;
         FP8:     return 5;
         FP16ALT: return 8;
         default: return 8;
      endcase
   endfunction

   function automatic int unsigned man_bits(input fp_format_e fmt);
      case (fmt)
         FP64:    return 52;
         FP16:    return 10;
         FP8:     return 2;
         FP16ALT: return 7;
         default: return 23;
      endcase
   endfunction

   function automatic int unsigned fp_width(input fp_format_e fmt);
      return 1 + exp_bits(fmt) + man_bits(fmt);
   endfunction

endpackage

// File: rtl/fpnew_classify_fmt.sv
// Combinational classifier for one operand in a runtime-selected format, including NaN-box check.
module fpnew_classify_fmt
   import fpnew_pkg::*;
#(
   parameter int unsigned Width        = 64,
   parameter bit          EnableNanBox = 1'b1
) (
   input  logic [Width-1:0]      operand_i,
   input  fp_format_e            src_fmt_i,
   output fp_info_t              info_o,
   output logic [CLASS_BITS-1:0] class_mask_o,
   output logic                  fmt_err_o
);

   int unsigned fmt_w, exp_w, man_w;
   logic sign, exp_zero, exp_ones, man_zero, man_msb, upper_ones;
   logic boxed, nan, sig;

   always_comb begin
      fmt_w      = fp_width(src_fmt_i);
      exp_w      = exp_bits(src_fmt_i);
      man_w      = man_bits(src_fmt_i);
      sign       = 1'b0;
      exp_zero   = 1'b1;
      exp_ones   = 1'b1;
      man_zero   = 1'b1;
      man_msb    = 1'b0;
      upper_ones = 1'b1;
      // Walk the register once, sorting each bit into mantissa, exponent, sign or box region
      for (int unsigned i = 0; i < Width; i++) begin
         if (i < man_w) begin
            if (operand_i[i]) man_zero = 1'b0;
            if (i == man_w - 1) man_msb = operand_i[i];
         end else if (i < man_w + exp_w) begin
            if (operand_i[i]) exp_zero = 1'b0;
            else              exp_ones = 1'b0;
         end else if (i == man_w + exp_w) begin
            sign = operand_i[i];
         end else if (!operand_i[i]) begin
            upper_ones = 1'b0;
         end
      end

      fmt_err_o = (fmt_w > Width);
      boxed     = !EnableNanBox || upper_ones;
      nan       = (exp_ones && !man_zero) || !boxed;
      sig       = boxed && exp_ones && !man_zero && !man_msb;

      info_o               = '0;
      info_o.is_normal     = boxed && !exp_zero && !exp_ones;
      info_o.is_subnormal  = boxed && exp_zero && !man_zero;
      info_o.is_zero       = boxed && exp_zero && man_zero;
      info_o.is_inf        = boxed && exp_ones && man_zero;
      info_o.is_nan        = nan;
      info_o.is_signalling = sig;
      info_o.is_quiet      = nan && !sig;
      info_o.is_boxed      = boxed;

      class_mask_o = '0;
      if (nan)                      class_mask_o[sig ? CLASS_SNAN : CLASS_QNAN] = 1'b1;
      else if (info_o.is_inf)       class_mask_o[sign ? CLASS_NEG_INF : CLASS_POS_INF] = 1'b1;
      else if (info_o.is_normal)    class_mask_o[sign ? CLASS_NEG_NORM : CLASS_POS_NORM] = 1'b1;
      else if (info_o.is_subnormal) class_mask_o[sign ? CLASS_NEG_SUBNORM : CLASS_POS_SUBNORM] = 1'b1;
      else                          class_mask_o[sign ? CLASS_NEG_ZERO : CLASS_POS_ZERO] = 1'b1;

      // Formats wider than the register produce no classification at all
      if (fmt_err_o) begin
         info_o       = '0;
         class_mask_o = '0;
      end
   end

endmodule

// File: rtl/fpnew_classifier_pipe.sv
// Multi-operand FP classifier followed by an elastic valid/ready pipeline with flush.
module fpnew_classifier_pipe
   import fpnew_pkg::*;
#(
   parameter int unsigned Width        = 64,
   parameter int unsigned NumOperands  = 3,
   parameter int unsigned NumPipeRegs  = 1,
   parameter bit          EnableNanBox = 1'b1,
   parameter int unsigned TagWidth     = 1
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [NumOperands*Width-1:0]      operands_i,
   input  fp_format_e                        src_fmt_i,
   input  logic [TagWidth-1:0]               tag_i,
   input  logic                              flush_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output fp_info_t [NumOperands-1:0]        info_o,
   output logic [NumOperands*CLASS_BITS-1:0] class_mask_o,
   output logic                              fmt_err_o,
   output logic [TagWidth-1:0]               tag_o,
   output logic                              busy_o
);

   localparam int unsigned InfoBits = NumOperands * $bits(fp_info_t);
   localparam int unsigned MaskBits = NumOperands * CLASS_BITS;
   localparam int unsigned PayloadW = TagWidth + 1 + MaskBits + InfoBits;

   fp_info_t [NumOperands-1:0] info_c;
   logic [MaskBits-1:0]        mask_c;
   logic [NumOperands-1:0]     err_c;

   for (genvar op = 0; op < NumOperands; op++) begin : g_cls
      fpnew_classify_fmt #(
         .Width        (Width),
         .EnableNanBox (EnableNanBox)
      ) u_cls (
         .operand_i    (operands_i[op*Width +: Width]),
         .src_fmt_i    (src_fmt_i),
         .info_o       (info_c[op]),
         .class_mask_o (mask_c[op*CLASS_BITS +: CLASS_BITS]),
         .fmt_err_o    (err_c[op])
      );
   end

   // Index 0 is the pipeline input; index s+1 is the output of register stage s
   logic [NumPipeRegs:0] valid;
   logic [NumPipeRegs:0] ready;
   logic [PayloadW-1:0]  data [NumPipeRegs+1];

   assign valid[0] = in_valid_i;
   assign data[0]  = {tag_i, |err_c, mask_c, info_c};

   always_comb begin
      ready              = '0;
      ready[NumPipeRegs] = out_ready_i;
      for (int s = int'(NumPipeRegs) - 1; s >= 0; s--) begin
         ready[s] = !valid[s+1] || ready[s+1];
      end
   end

   for (genvar s = 0; s < NumPipeRegs; s++) begin : g_stage
      logic                valid_q;
      logic [PayloadW-1:0] data_q;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else if (flush_i) begin
            valid_q <= 1'b0;
         end else if (ready[s]) begin
            valid_q <= valid[s];
            if (valid[s]) data_q <= data[s];
         end
      end

      assign valid[s+1] = valid_q;
      assign data[s+1]  = data_q;
   end

   assign in_ready_o  = ready[0];
   assign out_valid_o = valid[NumPipeRegs];
   assign {tag_o, fmt_err_o, class_mask_o, info_o} = data[NumPipeRegs];

   always_comb begin
      busy_o = 1'b0;
      for (int unsigned s = 1; s <= NumPipeRegs; s++) busy_o = busy_o | valid[s];
   end

endmodule

// File: tb/tb_fpnew_classifier_pipe.sv
// Self-checking bench: directed vectors, randomized model comparison, backpressure, flush, reset.
module tb_fpnew_classifier_pipe
   import fpnew_pkg::*;
;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Instance A: FP64 register, one stage
   logic          a_valid = 1'b0, a_ready, a_flush = 1'b0, a_ovalid, a_oready = 1'b1, a_err, a_busy;
   logic [191:0]  a_ops = '0;
   fp_format_e    a_fmt = FP32;
   logic [3:0]    a_tag = '0, a_otag;
   fp_info_t [2:0] a_info;
   logic [29:0]   a_mask;

   // Instance B: three stages for backpressure and flush
   logic          b_valid = 1'b0, b_ready, b_flush = 1'b0, b_ovalid, b_oready = 1'b1, b_err, b_busy;
   logic [191:0]  b_ops = '0;
   fp_format_e    b_fmt = FP32;
   logic [7:0]    b_tag = '0, b_otag;
   fp_info_t [2:0] b_info;
   logic [29:0]   b_mask;

   // Instance C: 32-bit register, combinational path
   logic          c_valid = 1'b0, c_ready, c_flush = 1'b0, c_ovalid, c_oready = 1'b1, c_err, c_busy;
   logic [31:0]   c_ops = '0;
   fp_format_e    c_fmt = FP32;
   logic [3:0]    c_tag = '0, c_otag;
   fp_info_t [0:0] c_info;
   logic [9:0]    c_mask;

   fpnew_classifier_pipe #(.Width(64), .NumOperands(3), .NumPipeRegs(1), .EnableNanBox(1'b1), .TagWidth(4)) u_a (
      .clk_i(clk), .rst_i(rst), .in_valid_i(a_valid), .in_ready_o(a_ready), .operands_i(a_ops),
      .src_fmt_i(a_fmt), .tag_i(a_tag), .flush_i(a_flush), .out_valid_o(a_ovalid), .out_ready_i(a_oready),
      .info_o(a_info), .class_mask_o(a_mask), .fmt_err_o(a_err), .tag_o(a_otag), .busy_o(a_busy));

   fpnew_classifier_pipe #(.Width(64), .NumOperands(3), .NumPipeRegs(3), .EnableNanBox(1'b1), .TagWidth(8)) u_b (
      .clk_i(clk), .rst_i(rst), .in_valid_i(b_valid), .in_ready_o(b_ready), .operands_i(b_ops),
      .src_fmt_i(b_fmt), .tag_i(b_tag), .flush_i(b_flush), .out_valid_o(b_ovalid), .out_ready_i(b_oready),
      .info_o(b_info), .class_mask_o(b_mask), .fmt_err_o(b_err), .tag_o(b_otag), .busy_o(b_busy));

   fpnew_classifier_pipe #(.Width(32), .NumOperands(1), .NumPipeRegs(0), .EnableNanBox(1'b1), .TagWidth(4)) u_c (
      .clk_i(clk), .rst_i(rst), .in_valid_i(c_valid), .in_ready_o(c_ready), .operands_i(c_ops),
      .src_fmt_i(c_fmt), .tag_i(c_tag), .flush_i(c_flush), .out_valid_o(c_ovalid), .out_ready_i(c_oready),
      .info_o(c_info), .class_mask_o(c_mask), .fmt_err_o(c_err), .tag_o(c_otag), .busy_o(c_busy));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] lowmask(input int unsigned n);
      return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
   endfunction

   function automatic void geom(input fp_format_e fmt, output int unsigned e, output int unsigned m);
      case (fmt)
         FP64:    begin e = 11; m = 52; end
         FP16:    begin e = 5;  m = 10; end
         FP8:     begin e = 5;  m = 2;  end
         FP16ALT: begin e = 8;  m = 7;  end
         default: begin e = 8;  m = 23; end
      endcase
   endfunction

   function automatic void ref_class(input logic [63:0] op_in, input fp_format_e fmt, input int unsigned W,
                                     output fp_info_t info, output logic [9:0] mask, output logic err);
      int unsigned e, m, w, idx;
      logic [63:0] op, val, ex, man;
      logic sign, boxed, special;
      geom(fmt, e, m);
      w    = 1 + e + m;
      info = '0;
      mask = '0;
      err  = (w > W);
      if (err) return;
      op    = op_in & lowmask(W);
      val   = op & lowmask(w);
      ex    = (val >> m) & lowmask(e);
      man   = val & lowmask(m);
      sign  = ((val >> (w - 1)) & 64'd1) != 0;
      boxed = (w == W) || ((op >> w) == lowmask(W - w));
      special = (ex == lowmask(e));
      info.is_boxed      = boxed;
      info.is_nan        = !boxed || (special && man != 0);
      info.is_signalling = boxed && special && man != 0 && ((man >> (m - 1)) & 64'd1) == 0;
      info.is_quiet      = info.is_nan && !info.is_signalling;
      info.is_inf        = boxed && special && man == 0;
      info.is_normal     = boxed && ex != 0 && !special;
      info.is_subnormal  = boxed && ex == 0 && man != 0;
      info.is_zero       = boxed && ex == 0 && man == 0;
      if (info.is_nan)            idx = info.is_signalling ? 8 : 9;
      else if (info.is_inf)       idx = sign ? 0 : 7;
      else if (info.is_normal)    idx = sign ? 1 : 6;
      else if (info.is_subnormal) idx = sign ? 2 : 5;
      else                        idx = sign ? 3 : 4;
      mask = 10'd1 << idx;
   endfunction

   function automatic logic [63:0] rand_op(input fp_format_e fmt, input int unsigned W);
      int unsigned e, m, w;
      logic [63:0] ex, man, sign, upper;
      geom(fmt, e, m);
      w = 1 + e + m;
      case ($urandom_range(0, 3))
         0:       ex = 64'd0;
         1:       ex = lowmask(e);
         default: ex = {$urandom(), $urandom()} & lowmask(e);
      endcase
      man   = ($urandom_range(0, 2) == 0) ? 64'd0 : ({$urandom(), $urandom()} & lowmask(m));
      sign  = 64'($urandom_range(0, 1));
      upper = ($urandom_range(0, 3) != 0) ? '1 : {$urandom(), $urandom()};
      if (w >= 64) upper = 64'd0;
      return ((upper << w) | (sign << (w - 1)) | (ex << m) | man) & lowmask(W);
   endfunction

   function automatic fp_format_e rand_fmt();
      return fp_format_e'(3'($urandom_range(0, 4)));
   endfunction

   // ---------------- instance A helpers ----------------
   task automatic a_txn(input logic [63:0] o0, input logic [63:0] o1, input logic [63:0] o2,
                        input fp_format_e fmt, input logic [3:0] tag);
      logic [63:0] ops [3];
      fp_info_t    info;
      logic [9:0]  mask;
      logic        err;
      ops[0] = o0; ops[1] = o1; ops[2] = o2;
      a_ops = {o2, o1, o0}; a_fmt = fmt; a_tag = tag; a_valid = 1'b1;
      #1 check("a_in_ready", 64'(a_ready), 64'd1);
      @(negedge clk);
      a_valid = 1'b0;
      check("a_out_valid", 64'(a_ovalid), 64'd1);
      check("a_tag", 64'(a_otag), 64'(tag));
      check("a_fmt_err", 64'(a_err), 64'd0);
      for (int k = 0; k < 3; k++) begin
         ref_class(ops[k], fmt, 64, info, mask, err);
         check($sformatf("a_info%0d", k), 64'(a_info[k]), 64'(info));
         check($sformatf("a_mask%0d", k), 64'(a_mask[k*10 +: 10]), 64'(mask));
      end
   endtask

   // ---------------- instance B helpers ----------------
   logic [37:0] b_q [$];
   logic        b_stalled = 1'b0;
   logic [38:0] b_snap;
   logic        b_acc = 1'b0;
   int          b_sent = 0;

   task automatic b_gen();
      b_fmt = rand_fmt();
      b_ops = {rand_op(b_fmt, 64), rand_op(b_fmt, 64), rand_op(b_fmt, 64)};
      b_tag = 8'(b_sent);
   endtask

   function automatic logic [37:0] b_expect();
      fp_info_t   info;
      logic [9:0] mask;
      logic       err;
      logic [29:0] all;
      all = '0;
      for (int k = 0; k < 3; k++) begin
         ref_class(b_ops[k*64 +: 64], b_fmt, 64, info, mask, err);
         all[k*10 +: 10] = mask;
      end
      return {b_tag, all};
   endfunction

   // Called #1 after a falling edge: checks held output, pops on output handshake, pushes on input handshake
   task automatic b_observe();
      logic [37:0] exp;
      if (b_stalled) begin
         check("b_stall_hold", 64'({b_ovalid, b_otag, b_mask}), 64'(b_snap));
         b_stalled = 1'b0;
      end
      if (b_ovalid && b_oready) begin
         exp = (b_q.size() > 0) ? b_q.pop_front() : '1;
         check("b_order", 64'({b_otag, b_mask}), 64'(exp));
      end
      if (b_ovalid && !b_oready) begin
         b_snap    = {b_ovalid, b_otag, b_mask};
         b_stalled = 1'b1;
      end
      b_acc = b_valid && b_ready;
      if (b_acc) begin
         b_q.push_back(b_expect());
         b_sent++;
      end
   endtask

   int bubbles;
   fp_info_t   c_ref_info;
   logic [9:0] c_ref_mask;
   logic       c_ref_err;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_a_valid", 64'(a_ovalid), 64'd0);
      check("rst_a_busy", 64'(a_busy), 64'd0);
      check("rst_a_out", 64'({a_otag, a_err, a_mask}), 64'd0);
      check("rst_b_valid", 64'(b_ovalid), 64'd0);
      check("rst_b_busy", 64'(b_busy), 64'd0);
      check("rst_b_out", 64'({b_otag, b_err, b_mask}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_a_ready", 64'(a_ready), 64'd1);
      check("post_rst_b_ready", 64'(b_ready), 64'd1);

      // Directed FP32: boxed +1.0, unboxed +1.0, boxed +inf
      a_txn(64'hFFFFFFFF_3F800000, 64'h00000000_3F800000, 64'hFFFFFFFF_7F800000, FP32, 4'h1);
      check("dir_fp32_norm", 64'(a_mask[9:0]), 64'h040);
      check("dir_fp32_unboxed", 64'(a_mask[19:10]), 64'h200);
      check("dir_fp32_unboxed_flag", 64'(a_info[1].is_boxed), 64'd0);
      check("dir_fp32_inf", 64'(a_mask[29:20]), 64'h080);
      @(negedge clk);

      // Directed FP64
      a_txn(64'h7FF0000000000000, 64'h7FF4000000000000, 64'hFFF8000000000000, FP64, 4'h2);
      check("dir_fp64_inf", 64'(a_mask[9:0]), 64'h080);
      check("dir_fp64_snan", 64'(a_mask[19:10]), 64'h100);
      check("dir_fp64_qnan", 64'(a_mask[29:20]), 64'h200);
      a_txn(64'h8000000000000000, 64'h0000000000000001, 64'hBFF0000000000000, FP64, 4'h3);
      check("dir_fp64_negzero", 64'(a_mask[9:0]), 64'h008);
      check("dir_fp64_possub", 64'(a_mask[19:10]), 64'h020);
      check("dir_fp64_negnorm", 64'(a_mask[29:20]), 64'h002);

      // Directed FP16 boxed sweep
      a_txn(64'hFFFFFFFFFFFFFC00, 64'hFFFFFFFFFFFF8001, 64'hFFFFFFFFFFFF7E00, FP16, 4'h4);
      check("dir_fp16_neginf", 64'(a_mask[9:0]), 64'h001);
      check("dir_fp16_negsub", 64'(a_mask[19:10]), 64'h004);
      check("dir_fp16_qnan", 64'(a_mask[29:20]), 64'h200);

      // Randomized operands against the model
      for (int i = 0; i < 30; i++) begin
         fp_format_e f;
         f = rand_fmt();
         a_txn(rand_op(f, 64), rand_op(f, 64), rand_op(f, 64), f, 4'(i));
      end

      // Combinational 32-bit instance: illegal format, legal formats, handshake passthrough
      c_valid = 1'b1; c_oready = 1'b1; c_fmt = FP64; c_ops = $urandom(); c_tag = 4'h5;
      #1;
      check("c_fmt_err", 64'(c_err), 64'd1);
      check("c_err_mask", 64'(c_mask), 64'd0);
      check("c_err_info", 64'(c_info), 64'd0);
      check("c_err_tag", 64'(c_otag), 64'h5);
      check("c_out_valid", 64'(c_ovalid), 64'd1);
      check("c_busy", 64'(c_busy), 64'd0);
      c_oready = 1'b0;
      #1 check("c_ready_pass", 64'(c_ready), 64'd0);
      c_oready = 1'b1; c_fmt = FP32; c_ops = 32'h3F800000;
      #1 check("c_fp32_norm", 64'({c_err, c_mask}), 64'h040);
      c_fmt = FP16; c_ops = 32'h00003C00;
      #1 check("c_fp16_unboxed", 64'(c_mask), 64'h200);
      for (int i = 0; i < 20; i++) begin
         c_fmt = rand_fmt();
         c_ops = 32'(rand_op(c_fmt, 32));
         c_tag = 4'(i);
         #1;
         ref_class(64'(c_ops), c_fmt, 32, c_ref_info, c_ref_mask, c_ref_err);
         check("c_rand", 64'({c_otag, c_err, c_info, c_mask}), 64'({4'(i), c_ref_err, c_ref_info, c_ref_mask}));
      end
      c_valid = 1'b0;

      // Instance B: continuous input with random backpressure, then ready held high
      @(negedge clk);
      b_gen();
      bubbles = 0;
      for (int cyc = 0; cyc < 120; cyc++) begin
         if (b_acc) b_gen();
         b_valid  = 1'b1;
         b_oready = (cyc < 80) ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (cyc >= 90 && !(b_ovalid && b_ready)) bubbles++;
         b_observe();
         @(negedge clk);
      end
      check("b_throughput_bubbles", 64'(bubbles), 64'd0);
      if (b_acc) b_gen();
      b_valid = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         #1 b_observe();
         @(negedge clk);
      end
      check("b_drained", 64'(b_q.size()), 64'd0);
      check("b_idle", 64'(b_busy), 64'd0);

      // Flush with three transactions in flight
      b_oready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b_gen(); b_valid = 1'b1;
         @(negedge clk);
      end
      check("b_full_busy", 64'(b_busy), 64'd1);
      check("b_full_valid", 64'(b_ovalid), 64'd1);
      b_gen(); b_oready = 1'b1; b_flush = 1'b1;
      #1 check("b_flush_accept", 64'(b_ready), 64'd1);
      @(negedge clk);
      b_flush = 1'b0;
      check("b_flush_valid", 64'(b_ovalid), 64'd0);
      check("b_flush_busy", 64'(b_busy), 64'd0);
      b_gen(); b_tag = 8'h5C;
      @(negedge clk);
      b_valid = 1'b0;
      check("b_lat1", 64'(b_ovalid), 64'd0);
      @(negedge clk);
      check("b_lat2", 64'(b_ovalid), 64'd0);
      @(negedge clk);
      check("b_lat3", 64'({b_ovalid, b_otag}), 64'({1'b1, 8'h5C}));
      @(negedge clk);

      // Reset mid-stream
      for (int i = 0; i < 4; i++) begin
         b_gen(); b_valid = 1'b1; b_oready = (i < 2);
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      check("midrst_b_valid", 64'(b_ovalid), 64'd0);
      check("midrst_b_busy", 64'(b_busy), 64'd0);
      check("midrst_b_out", 64'({b_otag, b_err, b_mask, b_info}), 64'd0);
      b_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_b_ready", 64'(b_ready), 64'd1);
      check("midrst_b_idle", 64'(b_ovalid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
